// File: rtl/i2c_cfg_master.sv
// I2C write master: sends a table of NUM_REGS 16-bit codec words as 3-byte writes to DEV_ADDR.
// Optional feature macro: I2C_CFG_RETRY_EN (resend a NACKed word up to MAX_RETRY extra times).
module i2c_cfg_master #(
   parameter int unsigned CLK_DIV   = 125,
   parameter int unsigned NUM_REGS  = 10,
   parameter int unsigned IDX_W     = 4,
   parameter logic [6:0]  DEV_ADDR  = 7'h1A,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      cfg_word,
   output logic [IDX_W-1:0] cfg_idx,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             I2C_SCLK,
   inout  wire              I2C_SDAT
);

   localparam int unsigned     QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0]   Q_LAST   = QW'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
   localparam logic [4:0]      BIT_LAST = 5'd26;

   if (CLK_DIV < 1 || NUM_REGS < 1 || NUM_REGS > (1 << IDX_W) || MAX_RETRY > 255) begin : g_param_check
      $error("i2c_cfg_master: illegal parameter set");
   end

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_GAP, ST_FIN
   } state_t;

   state_t      state, state_nx;
   logic [QW-1:0] qcnt;
   logic [1:0]  quarter;
   logic [4:0]  bit_cnt;
   logic [26:0] frame;
   logic        nack;
   logic        fin_ok;
   logic        sda_low;
   logic        tick, q_end, is_ack, ack_sample, gap_end, retry_ok;

   assign tick       = (qcnt == Q_LAST);
   assign q_end      = tick && (quarter == 2'd3);
   assign is_ack     = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == BIT_LAST);
   assign ack_sample = (state == ST_BIT) && (quarter == 2'd1) && tick && is_ack;
   assign gap_end    = (state == ST_GAP) && q_end;

`ifdef I2C_CFG_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] attempt;

   assign retry_ok = (attempt < RW'(MAX_RETRY));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         attempt <= '0;
      end else if (state == ST_IDLE && start && !busy) begin
         attempt <= '0;
      end else if (gap_end) begin
         if (!nack)
            attempt <= '0;
         else if (retry_ok)
            attempt <= attempt + RW'(1);
      end
   end
`else
   assign retry_ok = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      I2C_SCLK = 1'b1;
      sda_low  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !busy)
               state_nx = ST_START;
         end
         ST_START: begin
            sda_low = quarter[0];
            if (tick && quarter[0])
               state_nx = ST_BIT;
         end
         ST_BIT: begin
            // SCL high only in P1/P2; ACK slots carry 1 in the frame so SDA is released there
            I2C_SCLK = quarter[0] ^ quarter[1];
            sda_low  = ~frame[BIT_LAST - bit_cnt];
            if (q_end && (nack || bit_cnt == BIT_LAST))
               state_nx = ST_STOP;
         end
         ST_STOP: begin
            I2C_SCLK = (quarter != 2'd0);
            sda_low  = ~quarter[1];
            if (q_end)
               state_nx = ST_GAP;
         end
         ST_GAP: begin
            if (q_end) begin
               if (nack)
                  state_nx = retry_ok ? ST_START : ST_FIN;
               else if (cfg_idx == IDX_LAST)
                  state_nx = ST_FIN;
               else
                  state_nx = ST_START;
            end
         end
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qcnt    <= '0;
         quarter <= '0;
         bit_cnt <= '0;
         frame   <= '1;
         nack    <= 1'b0;
         fin_ok  <= 1'b0;
         cfg_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         if (state_nx != state || state == ST_IDLE || state == ST_FIN) begin
            qcnt    <= '0;
            quarter <= '0;
         end else if (tick) begin
            qcnt    <= '0;
            quarter <= quarter + 2'd1;
         end else begin
            qcnt <= qcnt + QW'(1);
         end

         if (state != ST_BIT)
            bit_cnt <= '0;
         else if (q_end)
            bit_cnt <= bit_cnt + 5'd1;

         // first clk of START: cfg_idx has already advanced, so cfg_word is the new entry
         if (state == ST_START && quarter == 2'd0 && qcnt == '0)
            frame <= {DEV_ADDR, 1'b0, 1'b1, cfg_word[15:8], 1'b1, cfg_word[7:0], 1'b1};

         if (state_nx == ST_START && state != ST_START)
            nack <= 1'b0;
         else if (ack_sample && I2C_SDAT)
            nack <= 1'b1;

         if (state == ST_IDLE && start && !busy) begin
            cfg_idx <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
         end

         if (gap_end) begin
            fin_ok <= !nack;
            if (!nack && cfg_idx != IDX_LAST)
               cfg_idx <= cfg_idx + IDX_W'(1);
         end

         if (state == ST_FIN) begin
            busy  <= 1'b0;
            done  <= fin_ok;
            error <= !fin_ok;
         end
      end
   end

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Scoreboarded bench for i2c_cfg_master: bus-decoding slave monitor plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_cfg_master;

   localparam int unsigned CD = 2;
   localparam int unsigned NR = 3;
   localparam int unsigned IW = 4;
   localparam int unsigned MR = 3;
   localparam logic [6:0]  DEV = 7'h1A;
   localparam int          LIMIT = 20000;
`ifdef I2C_CFG_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   cfg_word;
   logic [IW-1:0] cfg_idx;
   logic          busy, done, error, scl;
   logic          slave_low;
   wire           sda;
   logic [15:0]   tab [0:15];

   logic          start1;
   logic [15:0]   cfg_word1;
   logic [0:0]    cfg_idx1;
   logic          busy1, done1, error1, scl1;
   logic          slave1_low;
   wire           sda1;

   int checks = 0;
   int errors = 0;
   int n_start, n_stop, n_hichg, n_hichg1;
   int plan_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   pullup (sda);
   pullup (sda1);
   assign sda  = slave_low  ? 1'b0 : 1'bz;
   assign sda1 = slave1_low ? 1'b0 : 1'bz;
   assign cfg_word  = tab[cfg_idx];
   assign cfg_word1 = 16'hA5C3;

   i2c_cfg_master #(.CLK_DIV(CD), .NUM_REGS(NR), .IDX_W(IW), .DEV_ADDR(DEV), .MAX_RETRY(MR)) u_dut (
      .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .cfg_idx(cfg_idx),
      .busy(busy), .done(done), .error(error), .I2C_SCLK(scl), .I2C_SDAT(sda));

   i2c_cfg_master #(.CLK_DIV(1), .NUM_REGS(1), .IDX_W(1), .DEV_ADDR(7'h55), .MAX_RETRY(MR)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .cfg_word(cfg_word1), .cfg_idx(cfg_idx1),
      .busy(busy1), .done(done1), .error(error1), .I2C_SCLK(scl1), .I2C_SDAT(sda1));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Slave on the main bus: decodes START/STOP/bytes, ACKs per the plan, checks bytes against the scoreboard
   initial begin : slave
      logic sp, dp, sc, dc;
      int bitn, byte_i, cur_nack;
      logic [7:0] sh, e;
      slave_low = 1'b0; sp = 1'b1; dp = 1'b1;
      bitn = 0; byte_i = 0; cur_nack = 0; sh = '0;
      forever begin
         @(negedge clk);
         sc = scl;
         dc = (sda === 1'b0) ? 1'b0 : 1'b1;
         if (sp && sc && (dp != dc)) n_hichg++;
         if (reset) begin
            slave_low = 1'b0; bitn = 0; byte_i = 0;
         end else if (sp && sc && dp && !dc) begin
            n_start++; bitn = 0; byte_i = 0; slave_low = 1'b0;
            checks++;
            if (plan_q.size() == 0) begin
               errors++; cur_nack = 0;
               $display("FAIL start_expected: got START with %0d planned attempts left, required >0", plan_q.size());
            end else begin
               cur_nack = plan_q.pop_front();
            end
         end else if (sp && sc && !dp && dc) begin
            n_stop++; bitn = 0;
         end else if (!sp && sc) begin
            if (bitn < 8) sh = {sh[6:0], dc};
            bitn++;
         end else if (sp && !sc) begin
            if (bitn == 8) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL byte_expected: got byte 0x%02h with empty scoreboard", sh);
               end else begin
                  e = exp_q.pop_front();
                  chk("byte_value", sh, e);
               end
               slave_low = (cur_nack != byte_i + 1);
            end else if (bitn == 9) begin
               slave_low = 1'b0; bitn = 0; byte_i++;
            end
         end
         sp = sc; dp = dc;
      end
   end

   // Always-ACK slave for the single-word instance: low between the 9th and 10th SCL fall after START
   initial begin : slave1
      logic sp, dp, sc, dc;
      int falls;
      slave1_low = 1'b0; sp = 1'b1; dp = 1'b1; falls = 0;
      forever begin
         @(negedge clk);
         sc = scl1;
         dc = (sda1 === 1'b0) ? 1'b0 : 1'b1;
         if (sp && sc && (dp != dc)) n_hichg1++;
         if (reset) begin
            slave1_low = 1'b0; falls = 0;
         end else if (sp && sc && dp && !dc) begin
            falls = 0; slave1_low = 1'b0;
         end else if (sp && !sc) begin
            falls++;
            slave1_low = (falls % 9 == 0);
         end
         sp = sc; dp = dc;
      end
   end

   function automatic int choose(input int mode, input int idx, input int att);
      case (mode)
         0: return 0;
         1: return (idx == 1 && att == 0) ? 2 : 0;
         2: return 1;
         default: return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      endcase
   endfunction

   // Reference model: per attempt, k = NACKed byte (0 = all ACKed); fills plan and scoreboard
   task automatic model(input int mode, output int total, output int attempts, output int fidx, output bit ok);
      int k, nb;
      logic [7:0] bytes [3];
      ok = 1'b1; total = 0; attempts = 0; fidx = 0;
      for (int idx = 0; idx < NR && ok; idx++) begin
         int att = 0;
         bytes[0] = {DEV, 1'b0};
         bytes[1] = tab[idx][15:8];
         bytes[2] = tab[idx][7:0];
         forever begin
            k = choose(mode, idx, att);
            nb = (k == 0) ? 3 : k;
            plan_q.push_back(k);
            for (int b = 0; b < nb; b++) exp_q.push_back(bytes[b]);
            attempts++;
            total += (2 + 36 * nb + 8) * CD;
            fidx = idx;
            if (k == 0) break;
            if (RETRY && att < MR) att++;
            else begin ok = 1'b0; break; end
         end
      end
      total += 1;
   endtask

   task automatic accept();
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
   endtask

   task automatic run(input int mode, input int pulse_at, input int lit);
      int total, attempts, fidx, cyc;
      bit ok;
      for (int i = 0; i < 16; i++) tab[i] = 16'($urandom);
      model(mode, total, attempts, fidx, ok);
      n_start = 0; n_stop = 0; n_hichg = 0;
      accept();
      chk("busy_after_accept", busy, 1);
      chk("done_cleared", done, 0);
      chk("error_cleared", error, 0);
      cyc = 0;
      while (!(done || error) && cyc < LIMIT) begin
         start = (pulse_at > 0 && cyc == pulse_at);
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("run_latency", cyc, total);
      if (lit > 0) chk("run_latency_nominal", cyc, lit);
      chk("done_level", done, ok);
      chk("error_level", error, !ok);
      chk("busy_end", busy, 0);
      chk("cfg_idx_end", cfg_idx, fidx);
      repeat (6) @(negedge clk);
      chk("done_hold", done, ok);
      chk("error_hold", error, !ok);
      chk("bytes_left", exp_q.size(), 0);
      chk("attempts_left", plan_q.size(), 0);
      chk("start_count", n_start, attempts);
      chk("stop_count", n_stop, attempts);
      chk("sda_changes_scl_high", n_hichg, 2 * attempts);
      exp_q.delete(); plan_q.delete();
   endtask

   task automatic reset_mid();
      int total, attempts, fidx, cyc;
      bit ok;
      for (int i = 0; i < 16; i++) tab[i] = 16'($urandom);
      model(0, total, attempts, fidx, ok);
      accept();
      cyc = 0;
      // idx 2 begins 2*118*CD clks in; land inside bit 13 (byte 2 data)
      while (cyc < 2 * 118 * CD + 2 * CD + 13 * 4 * CD + 3) begin
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      chk("pre_reset_idx", cfg_idx, 2);
      #2 reset = 1'b1;
      #1;
      chk("reset_scl", scl, 1);
      chk("reset_sda_released", (sda === 1'b1), 1);
      chk("reset_busy", busy, 0);
      chk("reset_idx", cfg_idx, 0);
      @(negedge clk); reset = 1'b0;
      exp_q.delete(); plan_q.delete();
      repeat (4) @(negedge clk);
   endtask

   initial begin : stim
      int cyc;
      reset = 1'b1; start = 1'b0; start1 = 1'b0;
      n_start = 0; n_stop = 0; n_hichg = 0; n_hichg1 = 0;
      for (int i = 0; i < 16; i++) tab[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_scl", scl, 1);
      chk("rst_sda", (sda === 1'b1), 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_idx", cfg_idx, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 0, 709);
      run(0, 100, 709);
      run(1, 0, RETRY ? 873 : 401);
      run(2, 0, RETRY ? 4 * 92 + 1 : 93);
      reset_mid();
      run(0, 0, 709);
      for (int r = 0; r < 6; r++) run(3, int'($urandom_range(1, 300)), 0);

      n_hichg1 = 0;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk);
      @(negedge clk); start1 = 1'b0;
      cyc = 0;
      while (!(done1 || error1) && cyc < LIMIT) begin
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      chk("single_latency", cyc, 119);
      chk("single_done", done1, 1);
      chk("single_error", error1, 0);
      chk("single_idx", cfg_idx1, 0);
      chk("single_sda_changes_scl_high", n_hichg1, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule

// File: doc/i2c_cfg_master.md
# i2c_cfg_master

Parametrised I2C write master that programs the audio codec's control registers after reset, replacing the fixed single-table initialiser in the codec top. It walks an externally supplied table of `NUM_REGS` 16-bit codec words and sends each as a 3-byte write to `DEV_ADDR`. It checks the slave ACK after every byte and retries or flags failure on NACK. It sits between the top-level `start` source and the `I2C_SCLK`/`I2C_SDAT` pads.

## Interface
- `CLK_DIV`, 125: clk cycles per quarter SCL period (SCL period = 4*CLK_DIV); legal ≥ 1
- `NUM_REGS`, 10: number of table entries written per run; legal ≥ 1
- `IDX_W`, 4: width of `cfg_idx`; requires 2^IDX_W ≥ NUM_REGS
- `DEV_ADDR`, 7'h1A: 7-bit slave address; R/W bit is always 0
- `MAX_RETRY`, 3: extra attempts per word after a NACK (ignored without `I2C_CFG_RETRY_EN`)

Ports:
- `clk` in 1: system clock; all logic on the rising edge
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to run the whole table
- `cfg_word` in 16: table entry for `cfg_idx`, combinational lookup; `[15:9]` = register address, `[8:0]` = data
- `cfg_idx` out IDX_W: index of the word being sent
- `busy` out 1: high from start acceptance until `done` or `error`
- `done` out 1: level; all words ACKed
- `error` out 1: level; run aborted on NACK
- `I2C_SCLK` out 1: SCL, driven push-pull
- `I2C_SDAT` inout 1: SDA, open-drain; drives 0 or `z`, never 1

## Operation
- States: IDLE → START → BIT → STOP → GAP → (START | FIN); any state → IDLE on reset.
- IDLE: SCL=1, SDA released. When `start`=1 and `busy`=0:
  - `cfg_idx`←0
  - `done`, `error`←0
  - `busy`←1
  - attempt count←0
- `start` while `busy`=1 is ignored.
- START: 2 quarters. Q0: SDA released, SCL=1. Q1: SDA=0, SCL=1.
- BIT: 27 bits, MSB first. Bytes are {DEV_ADDR,0}, `cfg_word[15:8]`, `cfg_word[7:0]`; each byte is followed by one ACK bit with SDA released. `cfg_word` is latched at the entry of each START.
- Each bit takes 4 quarters, with SDA changing only at P0 start:
  - P0: SCL=0, SDA set
  - P1: SCL=1
  - P2: SCL=1
  - P3: SCL=0
- ACK sampling: SDA is sampled on the last clk of P1. 0 = ACK. 1 = NACK, which ends the bit loop at P3 and jumps to STOP.
- STOP: 4 quarters.
  - Q0: SCL=0, SDA=0
  - Q1: SCL=1, SDA=0
  - Q2: SCL=1, SDA released
  - Q3: idle
- GAP: 4 idle quarters, then:
  - All 3 ACKed and `cfg_idx`<NUM_REGS-1: `cfg_idx`+1, attempt count←0, go to START.
  - All 3 ACKed and `cfg_idx`=NUM_REGS-1: go to FIN with success.
  - NACK: retry handling (see Configuration).
- FIN (1 clk):
  - Success: `done`←1, `busy`←0, go to IDLE.
  - Abort: `error`←1, `busy`←0, go to IDLE.
- `done` and `error` are never both 1. Both hold until the next accepted `start`.

## Timing
- Reset values:
  - `I2C_SCLK`=1, `I2C_SDAT`=z
  - `busy`=0, `done`=0, `error`=0
  - `cfg_idx`=0
  - FSM=IDLE, counters 0
- Reset mid-transfer releases SDA and raises SCL asynchronously. No STOP is generated.
- The first START quarter begins the clk after `start` is sampled.
- One fully ACKed word = (2+108+4+4)·CLK_DIV = 118·CLK_DIV clks.
- Full successful run = NUM_REGS·118·CLK_DIV + 1 clks from acceptance to `done`.
- A NACK on byte k (k=1..3) ends that attempt after (2+36k+4+4)·CLK_DIV clks.
- SCL high time = 2·CLK_DIV. SDA never changes while SCL=1 except for START/STOP edges.

## Configuration
- `I2C_CFG_RETRY_EN` defined: a NACK with attempt count < MAX_RETRY increments the count and resends the same `cfg_idx` from START. With count = MAX_RETRY, the run aborts.
- Not defined: any NACK aborts immediately. `MAX_RETRY` is unused and the attempt counter is not built.

## Test plan
- Always-ACK slave model (pulls SDA low on every 9th bit), CLK_DIV=2, NUM_REGS=3:
  - Decoded bytes are 0x34, then cfg_word bytes, for idx 0,1,2.
  - `done`=1 exactly 709 clks after `start`.
  - `error`=0.
- Slave NACKs the first attempt of idx 1 on byte 2, retry enabled, MAX_RETRY=3:
  - idx 1 is re-sent once.
  - `done`=1.
  - Total clks = 709 + 2·(2+72+8) = 873.
- Slave always NACKs the address byte:
  - Retry enabled: 4 attempts, then `error`=1, `busy`=0, `cfg_idx`=0.
  - Retry disabled: `error` after 1 attempt, 2·(2+36+8)+1 = 93 clks.
- `reset` asserted in the middle of byte 2 of idx 2:
  - Immediately `I2C_SCLK`=1, SDA=z, `busy`=0, `cfg_idx`=0.
  - A new `start` then runs from idx 0.
- Pulse `start` during `busy`, and again after `done`:
  - The first pulse has no effect.
  - The second clears `done` in the next clk and reruns the table.
- NUM_REGS=1, CLK_DIV=1: a single word completes, with `done` at clk 119. SDA is stable throughout every SCL-high window.
